mult_result_collector: RTL and testbench

- Downstream of the shift-add multiplier controller/datapath.
- Captures the 16-bit product as it is presented on the shared 8-bit result bus: low byte on the Lsb_out strobe, then high byte on the Msb_out strobe in the following cycle.
- Reassembles each product and buffers it in a small FIFO.
- Presents products to the consumer with a valid/ready handshake and flags sequencing and overflow errors.

---
 rtl/mult_pkg.sv | 28 ++
 rtl/mult_prod_fifo.sv | 65 ++++++
 rtl/mult_result_collector.sv | 108 ++++++++++
 tb/tb_mult_result_collector.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: bus widths, controller
// state constants and the result-collector assembly FSM encoding.
package mult_pkg;

  localparam int MULT_DATA_WIDTH = 8;

  function automatic int prod_width(input int data_width);
    return 2 * data_width;
  endfunction

  // Multiplier controller sequencing; the collector only sees LSB_OUT/MSB_OUT.
  typedef enum logic [2:0] {
    CTRL_IDLE    = 3'd0,
    CTRL_INIT    = 3'd1,
    CTRL_TEST    = 3'd2,
    CTRL_ADD     = 3'd3,
    CTRL_SHIFT   = 3'd4,
    CTRL_LSB_OUT = 3'd5,
    CTRL_MSB_OUT = 3'd6,
    CTRL_DONE    = 3'd7
  } ctrl_state_t;

  typedef enum logic {
    WAIT_LSB = 1'b0,
    WAIT_MSB = 1'b1
  } asm_state_t;

endpackage

// File: rtl/mult_prod_fifo.sv
// Synchronous FIFO for assembled products with a registered head, valid and
// full. A push while full (without a pop) is ignored here.
module mult_prod_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             valid,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_next;
  logic [CNT_W-1:0] count, cnt_next;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] head_next;

  always_comb begin
    do_pop  = pop && valid;
    do_push = push && (!full || do_pop);
    rd_next = do_pop ? rd_ptr + 1'b1 : rd_ptr;
    cnt_next = count;
    case ({do_push, do_pop})
      2'b10:   cnt_next = count + 1'b1;
      2'b01:   cnt_next = count - 1'b1;
      default: cnt_next = count;
    endcase
    // The new entry becomes head only when it lands at the next read slot
    // (FIFO empty, or one entry being popped in the same cycle).
    head_next = (do_push && (wr_ptr == rd_next)) ? push_data : mem[rd_next];
  end

  // NOTE: storage is reset too so the head output reads 0 after reset; this
  // keeps the array in flops rather than a RAM macro, acceptable at this depth.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid     <= 1'b0;
      full      <= 1'b0;
      head_data <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      rd_ptr    <= rd_next;
      count     <= cnt_next;
      valid     <= (cnt_next != '0);
      full      <= (cnt_next == CNT_W'(DEPTH));
      head_data <= head_next;
    end
  end

endmodule

// File: rtl/mult_result_collector.sv
// Reassembles 16-bit products from the byte-wide multiplier result bus and
// buffers them for a valid/ready consumer. Optional MULT_PROD_CNT_EN adds o_prod_cnt.
module mult_result_collector
  import mult_pkg::*;
#(
  parameter int DATA_WIDTH = MULT_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [DATA_WIDTH-1:0]            i_data,
  input  logic                             i_lsb_vld,
  input  logic                             i_msb_vld,
  input  logic                             i_ready,
  output logic [prod_width(DATA_WIDTH)-1:0] o_prod,
  output logic                             o_valid,
  output logic                             o_full,
  output logic                             o_ovf,
  output logic                             o_seq_err
`ifdef MULT_PROD_CNT_EN
  ,
  output logic [15:0]                      o_prod_cnt
`endif
);

  localparam int PW = prod_width(DATA_WIDTH);

  asm_state_t            state, state_next;
  logic [DATA_WIDTH-1:0] low_reg;
  logic                  load_low, push, seq_err_set, pop, push_ok;
  logic [PW-1:0]         push_data;

  // NOTE: next-state logic defaults every output first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    load_low    = 1'b0;
    push        = 1'b0;
    seq_err_set = 1'b0;
    if (i_lsb_vld && i_msb_vld) begin
      seq_err_set = 1'b1;
      state_next  = WAIT_LSB;
    end else begin
      case (state)
        WAIT_LSB: begin
          if (i_lsb_vld) begin
            load_low   = 1'b1;
            state_next = WAIT_MSB;
          end else if (i_msb_vld) begin
            seq_err_set = 1'b1;
          end
        end
        WAIT_MSB: begin
          if (i_msb_vld) begin
            push       = 1'b1;
            state_next = WAIT_LSB;
          end else if (i_lsb_vld) begin
            seq_err_set = 1'b1;
            load_low    = 1'b1;
          end
        end
        default: state_next = WAIT_LSB;
      endcase
    end
  end

  assign push_data = {i_data, low_reg};
  assign pop       = o_valid && i_ready;
  assign push_ok   = push && (!o_full || pop);

  // NOTE: all state registers use non-blocking assignment so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= WAIT_LSB;
      low_reg   <= '0;
      o_ovf     <= 1'b0;
      o_seq_err <= 1'b0;
    end else begin
      state <= state_next;
      if (load_low)        low_reg   <= i_data;
      if (seq_err_set)     o_seq_err <= 1'b1;
      if (push && !push_ok) o_ovf    <= 1'b1;
    end
  end

`ifdef MULT_PROD_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)        o_prod_cnt <= '0;
    else if (push_ok) o_prod_cnt <= o_prod_cnt + 16'd1;
  end
`endif

  mult_prod_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (o_prod),
    .valid     (o_valid),
    .full      (o_full)
  );

endmodule

// File: tb/tb_mult_result_collector.sv
// Directed self-checking bench for mult_result_collector (default DEPTH=4).
module tb_mult_result_collector;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_data;
  logic        i_lsb_vld, i_msb_vld, i_ready;
  logic [15:0] o_prod;
  logic        o_valid, o_full, o_ovf, o_seq_err;
`ifdef MULT_PROD_CNT_EN
  logic [15:0] o_prod_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  mult_result_collector dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_data    (i_data),
    .i_lsb_vld (i_lsb_vld),
    .i_msb_vld (i_msb_vld),
    .i_ready   (i_ready),
    .o_prod    (o_prod),
    .o_valid   (o_valid),
    .o_full    (o_full),
    .o_ovf     (o_ovf),
    .o_seq_err (o_seq_err)
`ifdef MULT_PROD_CNT_EN
    ,
    .o_prod_cnt(o_prod_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs set before the call are sampled, outputs read after.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_data = 8'h00; i_lsb_vld = 1'b0; i_msb_vld = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_ready = 1'b0;
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_prod"},    32'(o_prod), 32'h0);
    check({tag, "_valid"},   32'(o_valid), 32'h0);
    check({tag, "_full"},    32'(o_full), 32'h0);
    check({tag, "_ovf"},     32'(o_ovf), 32'h0);
    check({tag, "_seq_err"}, 32'(o_seq_err), 32'h0);
  endtask

  task automatic send(input logic [15:0] prod);
    i_data = prod[7:0];  i_lsb_vld = 1'b1; i_msb_vld = 1'b0;
    step();
    i_data = prod[15:8]; i_lsb_vld = 1'b0; i_msb_vld = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic drain(input string tag, input logic [15:0] exp [4]);
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_valid%0d", tag, i), 32'(o_valid), 32'h1);
      check($sformatf("%s_prod%0d", tag, i), 32'(o_prod), 32'(exp[i]));
      step();
    end
    check({tag, "_empty"}, 32'(o_valid), 32'h0);
    i_ready = 1'b0;
  endtask

  logic [15:0] fill_vec [4] = '{16'h0001, 16'h0203, 16'h0405, 16'h0607};
  logic [15:0] swap_vec [4] = '{16'h2222, 16'h3333, 16'h4444, 16'hABCD};

  initial begin
    idle_inputs();
    i_ready = 1'b0;
    i_rst   = 1'b0;
    do_reset();
    check_reset_state("rst0");

    // Basic capture
    i_data = 8'h34; i_lsb_vld = 1'b1;
    step();
    check("basic_no_early_valid", 32'(o_valid), 32'h0);
    i_data = 8'h12; i_lsb_vld = 1'b0; i_msb_vld = 1'b1;
    step();
    idle_inputs();
    check("basic_valid", 32'(o_valid), 32'h1);
    check("basic_prod", 32'(o_prod), 32'h1234);
    check("basic_seq_err", 32'(o_seq_err), 32'h0);
    step();
    check("basic_hold", 32'(o_prod), 32'h1234);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    check("basic_popped", 32'(o_valid), 32'h0);

    // Fill, overflow, drain in order
    for (int i = 0; i < 4; i++) send(fill_vec[i]);
    check("fill_full", 32'(o_full), 32'h1);
    check("fill_no_ovf", 32'(o_ovf), 32'h0);
    send(16'hFFFF);
    check("ovf_set", 32'(o_ovf), 32'h1);
    check("ovf_still_full", 32'(o_full), 32'h1);
    check("ovf_head", 32'(o_prod), 32'h0001);
    drain("fill", fill_vec);
    check("ovf_sticky", 32'(o_ovf), 32'h1);
    check("fill_not_full", 32'(o_full), 32'h0);

    do_reset();
    check_reset_state("rst1");

    // Full with simultaneous pop on the MSB push
    send(16'h1111); send(16'h2222); send(16'h3333); send(16'h4444);
    check("swap_full", 32'(o_full), 32'h1);
    i_data = 8'hCD; i_lsb_vld = 1'b1;
    step();
    i_data = 8'hAB; i_lsb_vld = 1'b0; i_msb_vld = 1'b1; i_ready = 1'b1;
    step();
    idle_inputs();
    i_ready = 1'b0;
    check("swap_no_ovf", 32'(o_ovf), 32'h0);
    check("swap_full_after", 32'(o_full), 32'h1);
    drain("swap", swap_vec);

    // MSB strobe while waiting for LSB
    do_reset();
    i_data = 8'h99; i_msb_vld = 1'b1;
    step();
    idle_inputs();
    check("msb_first_err", 32'(o_seq_err), 32'h1);
    check("msb_first_no_push", 32'(o_valid), 32'h0);

    // Both strobes together, starting mid-capture
    do_reset();
    i_data = 8'h11; i_lsb_vld = 1'b1;
    step();
    i_data = 8'h22; i_lsb_vld = 1'b1; i_msb_vld = 1'b1;
    step();
    idle_inputs();
    check("both_err", 32'(o_seq_err), 32'h1);
    check("both_no_push", 32'(o_valid), 32'h0);
    // A lone MSB now must be rejected: FSM was forced back to WAIT_LSB
    i_data = 8'h33; i_msb_vld = 1'b1;
    step();
    idle_inputs();
    check("both_forced_lsb", 32'(o_valid), 32'h0);
    send(16'hAA55);
    check("both_recover_valid", 32'(o_valid), 32'h1);
    check("both_recover_prod", 32'(o_prod), 32'hAA55);

    // Repeated LSB overwrites the low byte
    do_reset();
    i_data = 8'h01; i_lsb_vld = 1'b1;
    step();
    i_data = 8'h02;
    step();
    check("rep_lsb_err", 32'(o_seq_err), 32'h1);
    i_data = 8'h03; i_lsb_vld = 1'b0; i_msb_vld = 1'b1;
    step();
    idle_inputs();
    check("rep_lsb_prod", 32'(o_prod), 32'h0302);

    // Reset mid-capture
    do_reset();
    i_data = 8'h77; i_lsb_vld = 1'b1;
    step();
    idle_inputs();
    do_reset();
    check_reset_state("rst_mid");
    i_data = 8'h12; i_msb_vld = 1'b1;
    step();
    idle_inputs();
    check("rst_mid_err", 32'(o_seq_err), 32'h1);
    check("rst_mid_no_push", 32'(o_valid), 32'h0);

`ifdef MULT_PROD_CNT_EN
    do_reset();
    check("cnt_rst", 32'(o_prod_cnt), 32'h0);
    for (int i = 0; i < 4; i++) send(fill_vec[i]);
    send(16'hFFFF);
    check("cnt_drop", 32'(o_prod_cnt), 32'h4);
    i_ready = 1'b1;
    send(16'h0A0B);
    i_ready = 1'b0;
    check("cnt_swap", 32'(o_prod_cnt), 32'h5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
